uart_tx_with_mcu: RTL
=====================

Name: uart_tx_with_mcu

Overview:
8N1 RS232 transmitter. It serialises bytes from the MCU-side register interface onto rs232_tx and is the transmit counterpart of the existing 20 MHz UART receive path. It has its own bit-period timer, so no external clk_bps or bps_start is needed. A one-deep holding register allows back-to-back frames with no idle gap.

Parameters:
- CLK_FREQ, 20000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
- BPS_DIV, CLK_FREQ/BAUD (integer division), clock cycles per bit. Derived; must be >= 2.

Ports:
- clk, input, 1, system clock (20 MHz).
- rst, input, 1, asynchronous active-low reset.
- tx_data, input, 8, byte to send; sampled when tx_valid && tx_ready.
- tx_valid, input, 1, MCU offers tx_data.
- tx_ready, output, 1, holding register empty; the byte is accepted this cycle if tx_valid=1.
- rs232_tx, output, 1, serial line; idles high.
- tx_int, output, 1, high while a frame is on the line (start bit through last stop bit).
- tx_done, output, 1, one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset (rst=0, asynchronous):
  - rs232_tx=1, tx_ready=1, tx_int=0, tx_done=0.
  - State = IDLE; holding register and baud counter cleared.
- Accept and holding register:
  - Accept occurs on a rising edge with tx_valid && tx_ready. The byte goes into the holding register (hold_full=1).
  - tx_ready = !hold_full, registered.
- State machine: IDLE -> START -> DATA -> STOP -> (IDLE | START).
  - IDLE, hold_full=1: load the shift register from hold, clear hold_full, go to START on the next edge. The line falls 1 cycle after the accepting edge.
  - START: rs232_tx=0 for exactly BPS_DIV cycles.
  - DATA: 8 bits, LSB first, each exactly BPS_DIV cycles. A 3-bit bit index runs 0..7.
  - STOP: rs232_tx=1 for STOP_BITS*BPS_DIV cycles. On the final cycle, tx_done=1 for one cycle.
  - Leaving STOP: if hold_full, reload and go directly to START on the next edge (no idle bit). Otherwise go to IDLE.
- Frame length: (9+STOP_BITS)*BPS_DIV cycles, with no jitter. All bit edges are driven from registers, so rs232_tx is glitch-free.
- Baud counter:
  - Counts 0..BPS_DIV-1, width $clog2(BPS_DIV).
  - Reset to 0 on every state entry; the bit boundary is at count==BPS_DIV-1.
  - Held at 0 in IDLE.
- Simultaneous events:
  - Accept in the same cycle the shift register loads from hold: the new byte lands in hold. tx_ready drops for at most 1 cycle in this case.
  - tx_valid while tx_ready=0 is ignored; the MCU must hold tx_data and tx_valid until accepted.
- tx_int: 1 from START entry to STOP exit. It stays 1 across back-to-back frames.
- Reset mid-frame: line high immediately, frame aborted, held byte discarded, no tx_done.
- tx_data changing after accept has no effect on the frame in flight.

Decomposition:
- Package uart_pkg:
  - State encoding localparams IDLE, START, DATA, STOP (2-bit).
  - DATA_BITS=8.
  - Function for BPS_DIV and counter width from CLK_FREQ/BAUD.
  - Shared with the receive side.
- Sub-module uart_bps_cnt: a baud counter with clear and enable inputs and a bit_end tick output. It is instantiable later by the receive path.
- Top: FSM, shift register, holding register.

Test Plan (CLK_FREQ=400, BAUD=100, so BPS_DIV=4, STOP_BITS=1 unless noted):
- Reset, then idle 50 cycles -> rs232_tx=1, tx_ready=1, tx_int=0, tx_done never asserted.
- Send 0xA5 (tx_valid for 1 cycle) -> line falls 1 cycle after accept. The 40-cycle frame reads 0,1,0,1,0,0,1,0,1,1 per 4-cycle bit. tx_done pulses once on cycle 40.
- Send 0x00 then 0xFF with tx_valid held continuously -> second byte accepted during the first frame. Frames are contiguous (80 cycles, no idle bit), tx_int high throughout, 2 tx_done pulses.
- Three bytes offered back-to-back -> third stalls with tx_ready=0 until the first frame finishes. All three are transmitted in order and none is lost.
- Assert rst mid-data-bit of 0x3C -> rs232_tx=1 asynchronously, tx_int=0, no tx_done. After release, 0x81 transmits correctly.
- STOP_BITS=2, send 0x55 -> frame is 44 cycles with the stop high for 8 cycles; tx_done is on the last cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the transmit and receive paths
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int calc_bps_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int calc_cnt_w(input int bps_div);
        return (bps_div > 1) ? $clog2(bps_div) : 1;
    endfunction

endpackage

// File: rtl/uart_bps_cnt.sv
// rtl/uart_bps_cnt.sv - bit-period counter with clear/enable and bit_end tick
module uart_bps_cnt
    import uart_pkg::*;
#(
    parameter int BPS_DIV = 4,
    parameter int CNT_W   = calc_cnt_w(BPS_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             bit_end
);

    assign bit_end = en && (cnt == CNT_W'(BPS_DIV - 1));

    // Wrapping at bit_end means every state change lands on a fresh count of 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_with_mcu.sv
// rtl/uart_tx_with_mcu.sv - 8N1 RS232 transmitter with one-deep holding register
module uart_tx_with_mcu
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 20000000,
    parameter int BAUD      = 9600,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rs232_tx,
    output logic       tx_int,
    output logic       tx_done
);

    localparam int         BPS_DIV   = calc_bps_div(CLK_FREQ, BAUD);
    localparam int         CNT_W     = calc_cnt_w(BPS_DIV);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] hold_reg;
    logic                 hold_full;
    logic [2:0]           bit_idx;
    logic [CNT_W-1:0]     cnt;
    logic                 bit_end;
    logic                 accept;
    logic                 stop_last;
    logic                 load;
    logic                 hold_full_next;
    logic                 done_next;

    uart_bps_cnt #(
        .BPS_DIV (BPS_DIV),
        .CNT_W   (CNT_W)
    ) u_bps_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .en      (state != IDLE),
        .cnt     (cnt),
        .bit_end (bit_end)
    );

    assign accept         = tx_valid && tx_ready;
    assign stop_last      = (state == STOP) && (bit_idx == LAST_STOP);
    assign load           = hold_full && ((state == IDLE) || (stop_last && bit_end));
    assign hold_full_next = accept || (hold_full && !load);
    // Registered tx_done must rise one cycle early to sit on the final stop cycle.
    assign done_next      = stop_last && (cnt == CNT_W'(BPS_DIV - 2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
            tx_ready  <= 1'b1;
        end else begin
            if (accept) begin
                hold_reg <= tx_data;
            end
            hold_full <= hold_full_next;
            tx_ready  <= !hold_full_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            rs232_tx  <= 1'b1;
            tx_int    <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= done_next;
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        shift_reg <= hold_reg;
                        rs232_tx  <= 1'b0;
                        tx_int    <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        rs232_tx  <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
                        bit_idx   <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_BIT) begin
                            rs232_tx <= 1'b1;
                            bit_idx  <= '0;
                            state    <= STOP;
                        end else begin
                            rs232_tx  <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (bit_idx != LAST_STOP) begin
                            bit_idx <= bit_idx + 1'b1;
                        end else if (hold_full) begin
                            shift_reg <= hold_reg;
                            rs232_tx  <= 1'b0;
                            state     <= START;
                        end else begin
                            tx_int <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
